// File: rtl/wb_ddr2_arb_pkg.sv
// Shared types and helpers for the DDR2 frame-buffer Wishbone arbiter.
package wb_ddr2_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StG0,
      StG1,
      StAbort
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts enabled cycles and flags expiry on the last allowed one.
module wb_arb_watchdog
   import wb_ddr2_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CntW = cnt_width(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CntLast)) begin
         cnt_d = cnt_q + 1'b1;
      end
      expire_o = en_i & (cnt_q == CntLast);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_ddr2_arbiter.sv
// Two-master Wishbone arbiter in front of the DDR2 slave: priority to m0 with a
// starvation guard for m1, and a watchdog that aborts stalled transfers.
module wb_ddr2_arbiter
   import wb_ddr2_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic [31:0] m0_adr_i,
   input  logic [1:0]  m0_bte_i,
   input  logic [2:0]  m0_cti_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [7:0]  m0_sel_i,
   input  logic [63:0] m0_dat_i,
   output logic [63:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_rty_o,
   input  logic [31:0] m1_adr_i,
   input  logic [1:0]  m1_bte_i,
   input  logic [2:0]  m1_cti_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [7:0]  m1_sel_i,
   input  logic [63:0] m1_dat_i,
   output logic [63:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_rty_o,
   output logic [31:0] s_adr_o,
   output logic [1:0]  s_bte_o,
   output logic [2:0]  s_cti_o,
   output logic [7:0]  s_sel_o,
   output logic [63:0] s_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   input  logic [63:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);

   localparam int unsigned ConsecW = cnt_width(MAX_CONSEC + 1);
   localparam logic [ConsecW-1:0] ConsecMax = ConsecW'(MAX_CONSEC);

   arb_state_e         state_q, state_d;
   logic [ConsecW-1:0] consec_q, consec_d;
   logic [1:0]         grant_q;
   logic               abort_m1_q, abort_m1_d;
   logic               r0, r1, in_g0, in_g1, resp, stall, expire, wdog_clr;

   assign r0    = m0_cyc_i & m0_stb_i;
   assign r1    = m1_cyc_i & m1_stb_i;
   assign in_g0 = (state_q == StG0);
   assign in_g1 = (state_q == StG1);
   assign resp  = s_ack_i | s_err_i | s_rty_i;

   always_comb begin
      s_adr_o = '0;
      s_bte_o = '0;
      s_cti_o = '0;
      s_sel_o = '0;
      s_dat_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      if (in_g0) begin
         {s_adr_o, s_bte_o, s_cti_o, s_sel_o, s_dat_o} =
            {m0_adr_i, m0_bte_i, m0_cti_i, m0_sel_i, m0_dat_i};
         {s_cyc_o, s_stb_o, s_we_o} = {m0_cyc_i, m0_stb_i, m0_we_i};
      end else if (in_g1) begin
         {s_adr_o, s_bte_o, s_cti_o, s_sel_o, s_dat_o} =
            {m1_adr_i, m1_bte_i, m1_cti_i, m1_sel_i, m1_dat_i};
         {s_cyc_o, s_stb_o, s_we_o} = {m1_cyc_i, m1_stb_i, m1_we_i};
      end
   end

   assign stall = (in_g0 | in_g1) & s_stb_o & ~resp;

   always_comb begin
      state_d    = state_q;
      consec_d   = consec_q;
      abort_m1_d = abort_m1_q;
      case (state_q)
         StIdle: begin
            if (r1 && (!r0 || (consec_q == ConsecMax))) begin
               state_d  = StG1;
               consec_d = '0;
            end else if (r0) begin
               state_d = StG0;
            end
         end
         StG0: begin
            if (expire) begin
               state_d    = StAbort;
               abort_m1_d = 1'b0;
            end else if (!m0_cyc_i) begin
               state_d = StIdle;
            end
            // m1 still waiting at G0 exit: charge one more turn to m0.
            if (state_d != StG0) begin
               if (!m1_cyc_i) begin
                  consec_d = '0;
               end else if (consec_q != ConsecMax) begin
                  consec_d = consec_q + 1'b1;
               end
            end
         end
         StG1: begin
            if (expire) begin
               state_d    = StAbort;
               abort_m1_d = 1'b1;
            end else if (!m1_cyc_i) begin
               state_d = StIdle;
            end
         end
         StAbort: begin
            if (!(abort_m1_q ? m1_cyc_i : m0_cyc_i)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign wdog_clr = resp | (state_d != state_q);

   wb_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i    (wb_clk),
      .rst_i    (wb_rst),
      .clr_i    (wdog_clr),
      .en_i     (stall),
      .expire_o (expire)
   );

   assign m0_dat_o  = (in_g0 | in_g1) ? s_dat_i : '0;
   assign m1_dat_o  = (in_g0 | in_g1) ? s_dat_i : '0;
   assign m0_ack_o  = in_g0 & s_ack_i;
   assign m0_err_o  = in_g0 & (s_err_i | expire);
   assign m0_rty_o  = in_g0 & s_rty_i;
   assign m1_ack_o  = in_g1 & s_ack_i;
   assign m1_err_o  = in_g1 & (s_err_i | expire);
   assign m1_rty_o  = in_g1 & s_rty_i;
   assign timeout_o = expire;
   assign grant_o   = grant_q;

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q    <= StIdle;
         consec_q   <= '0;
         abort_m1_q <= 1'b0;
         grant_q    <= GNT_NONE;
      end else begin
         state_q    <= state_d;
         consec_q   <= consec_d;
         abort_m1_q <= abort_m1_d;
         grant_q    <= (state_d == StG0) ? GNT_M0 : (state_d == StG1) ? GNT_M1 : GNT_NONE;
      end
   end

endmodule

// File: tb/tb_wb_ddr2_arbiter.sv
// Self-checking bench for wb_ddr2_arbiter; the bench plays both masters and the slave.
module tb_wb_ddr2_arbiter;

   logic        wb_clk, wb_rst;
   logic [31:0] m0_adr_i, m1_adr_i;
   logic [1:0]  m0_bte_i, m1_bte_i;
   logic [2:0]  m0_cti_i, m1_cti_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [7:0]  m0_sel_i, m1_sel_i;
   logic [63:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
   logic [31:0] s_adr_o;
   logic [1:0]  s_bte_o;
   logic [2:0]  s_cti_o;
   logic [7:0]  s_sel_o;
   logic [63:0] s_dat_o, s_dat_i;
   logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
   logic [1:0]  grant_o;
   logic        timeout_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        m1;
      logic [63:0] dat;
   } exp_t;
   exp_t exp_q[$];

   wb_ddr2_arbiter #(
      .TIMEOUT    (16),
      .MAX_CONSEC (4)
   ) dut (
      .wb_clk    (wb_clk),
      .wb_rst    (wb_rst),
      .m0_adr_i  (m0_adr_i),
      .m0_bte_i  (m0_bte_i),
      .m0_cti_i  (m0_cti_i),
      .m0_cyc_i  (m0_cyc_i),
      .m0_stb_i  (m0_stb_i),
      .m0_we_i   (m0_we_i),
      .m0_sel_i  (m0_sel_i),
      .m0_dat_i  (m0_dat_i),
      .m0_dat_o  (m0_dat_o),
      .m0_ack_o  (m0_ack_o),
      .m0_err_o  (m0_err_o),
      .m0_rty_o  (m0_rty_o),
      .m1_adr_i  (m1_adr_i),
      .m1_bte_i  (m1_bte_i),
      .m1_cti_i  (m1_cti_i),
      .m1_cyc_i  (m1_cyc_i),
      .m1_stb_i  (m1_stb_i),
      .m1_we_i   (m1_we_i),
      .m1_sel_i  (m1_sel_i),
      .m1_dat_i  (m1_dat_i),
      .m1_dat_o  (m1_dat_o),
      .m1_ack_o  (m1_ack_o),
      .m1_err_o  (m1_err_o),
      .m1_rty_o  (m1_rty_o),
      .s_adr_o   (s_adr_o),
      .s_bte_o   (s_bte_o),
      .s_cti_o   (s_cti_o),
      .s_sel_o   (s_sel_o),
      .s_dat_o   (s_dat_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_dat_i   (s_dat_i),
      .s_ack_i   (s_ack_i),
      .s_err_i   (s_err_i),
      .s_rty_i   (s_rty_i),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   initial wb_clk = 1'b0;
   always #5 wb_clk = ~wb_clk;

   // Scoreboard: every forwarded ack must match the oldest expected response.
   always @(negedge wb_clk) begin
      if (m0_ack_o || m1_ack_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ack got m0_ack=%b m1_ack=%b required none", m0_ack_o,
                     m1_ack_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (m1_ack_o !== e.m1 || m0_ack_o !== !e.m1 ||
                (e.m1 ? m1_dat_o : m0_dat_o) !== e.dat) begin
               errors++;
               $display("FAIL sb_ack got m0_ack=%b m1_ack=%b dat=%h required m1=%b dat=%h",
                        m0_ack_o, m1_ack_o, e.m1 ? m1_dat_o : m0_dat_o, e.m1, e.dat);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge wb_clk);
   endtask

   task automatic slave_ack(input logic m1, input logic [63:0] d);
      exp_t e;
      s_ack_i = 1'b1;
      s_dat_i = d;
      e.m1  = m1;
      e.dat = d;
      exp_q.push_back(e);
   endtask

   task automatic m0_req(input logic on);
      m0_cyc_i = on;
      m0_stb_i = on;
   endtask

   task automatic m1_req(input logic on);
      m1_cyc_i = on;
      m1_stb_i = on;
   endtask

   task automatic test_reset();
      m0_adr_i = 32'h0;  m1_adr_i = 32'h0;  m0_bte_i = 2'b0; m1_bte_i = 2'b0;
      m0_cti_i = 3'b0;   m1_cti_i = 3'b0;   m0_we_i = 1'b0;  m1_we_i = 1'b0;
      m0_sel_i = 8'hff;  m1_sel_i = 8'hff;  m0_dat_i = '0;   m1_dat_i = '0;
      m0_req(1'b0); m1_req(1'b0);
      s_dat_i = 64'hdead_beef_0000_0001; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      wb_rst = 1'b1;
      next_cycle();
      next_cycle();
      sample();
      checks++;
      if ({grant_o, s_cyc_o, s_stb_o, timeout_o, m0_err_o, m1_err_o} !== 7'b0 ||
          s_adr_o !== 32'h0 || m0_dat_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_outputs got grant=%b cyc=%b stb=%b to=%b adr=%h dat=%h required 0",
                  grant_o, s_cyc_o, s_stb_o, timeout_o, s_adr_o, m0_dat_o);
      end
      next_cycle();
      wb_rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_m0_burst();
      int acks = 0;
      m0_req(1'b1);
      m0_adr_i = 32'h0000_1000;
      m0_cti_i = 3'b010;
      sample();
      checks++;
      if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
         errors++;
         $display("FAIL burst_req_cycle got cyc=%b grant=%b required cyc=0 grant=00", s_cyc_o,
                  grant_o);
      end
      next_cycle();
      for (int k = 0; k < 8; k++) begin
         m0_adr_i = 32'h0000_1000 + 32'(k * 8);
         m0_cti_i = (k == 7) ? 3'b111 : 3'b010;
         slave_ack(1'b0, {32'hca5e_0000 | 32'(k), $urandom});
         sample();
         checks++;
         if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_adr_o !== m0_adr_i ||
             s_cti_o !== m0_cti_i || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_beat%0d got grant=%b cyc=%b adr=%h cti=%b m1_ack=%b required 01 1 %h %b 0",
                     k, grant_o, s_cyc_o, s_adr_o, s_cti_o, m1_ack_o, m0_adr_i, m0_cti_i);
         end
         if (m0_ack_o) acks++;
         next_cycle();
      end
      m0_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      sample();
      checks++;
      if (acks != 8 || grant_o !== 2'b00) begin
         errors++;
         $display("FAIL burst_ack_count got acks=%0d grant=%b required 8 00", acks, grant_o);
      end
      next_cycle();
   endtask

   task automatic test_simultaneous();
      int n;
      m0_req(1'b1);
      m1_req(1'b1);
      m1_we_i  = 1'b1;
      m1_dat_i = 64'h1111_2222_3333_4444;
      m1_adr_i = 32'h0000_8000;
      next_cycle();
      slave_ack(1'b0, 64'h0123_4567_89ab_cdef);
      sample();
      checks++;
      if (grant_o !== 2'b01 || m1_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL simul_first_owner got grant=%b m1_ack=%b required 01 0", grant_o, m1_ack_o);
      end
      next_cycle();
      m0_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      for (n = 1; n <= 6; n++) begin
         sample();
         if (grant_o === 2'b10) break;
         next_cycle();
      end
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL simul_handover_gap got %0d cycles required 2", n);
      end
      next_cycle();
      slave_ack(1'b1, 64'h0);
      sample();
      checks++;
      if (s_we_o !== 1'b1 || s_dat_o !== m1_dat_i || s_adr_o !== m1_adr_i || m0_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL simul_m1_write got we=%b dat=%h adr=%h m0_ack=%b required 1 %h %h 0",
                  s_we_o, s_dat_o, s_adr_o, m0_ack_o, m1_dat_i, m1_adr_i);
      end
      next_cycle();
      m1_req(1'b0);
      m1_we_i = 1'b0;
      s_ack_i = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_consec();
      m1_req(1'b1);
      for (int i = 0; i < 4; i++) begin
         m0_req(1'b1);
         next_cycle();
         slave_ack(1'b0, 64'h5000 + 64'(i));
         sample();
         checks++;
         if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL consec_m0_turn%0d got grant=%b required 01", i, grant_o);
         end
         next_cycle();
         m0_req(1'b0);
         s_ack_i = 1'b0;
         next_cycle();
      end
      m0_req(1'b1);
      next_cycle();
      sample();
      checks++;
      if (grant_o !== 2'b10) begin
         errors++;
         $display("FAIL consec_starve_grant got grant=%b required 10", grant_o);
      end
      next_cycle();
      slave_ack(1'b1, 64'h6000);
      next_cycle();
      m1_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      m1_req(1'b1);
      next_cycle();
      sample();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++;
         $display("FAIL consec_cleared got grant=%b required 01", grant_o);
      end
      next_cycle();
      slave_ack(1'b0, 64'h7000);
      next_cycle();
      m0_req(1'b0);
      m1_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_timeout();
      int pulses = 0;
      int at = 0;
      int err_miss = 0;
      m1_req(1'b1);
      m1_we_i = 1'b1;
      next_cycle();
      for (int i = 1; i <= 16; i++) begin
         sample();
         if (timeout_o) begin
            pulses++;
            at = i;
            if (!m1_err_o || m0_err_o) err_miss++;
         end else if (m1_err_o) begin
            err_miss++;
         end
         next_cycle();
      end
      checks++;
      if (pulses != 1 || at != 16 || err_miss != 0) begin
         errors++;
         $display("FAIL timeout_pulse got pulses=%0d at=%0d err_miss=%0d required 1 16 0", pulses,
                  at, err_miss);
      end
      s_ack_i = 1'b1;
      sample();
      checks++;
      if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort got cyc=%b stb=%b m1_ack=%b to=%b required 0 0 0 0", s_cyc_o,
                  s_stb_o, m1_ack_o, timeout_o);
      end
      next_cycle();
      m1_req(1'b0);
      m1_we_i = 1'b0;
      s_ack_i = 1'b0;
      next_cycle();
      m0_req(1'b1);
      next_cycle();
      sample();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++;
         $display("FAIL timeout_recover got grant=%b required 01", grant_o);
      end
      next_cycle();
      slave_ack(1'b0, 64'h8000);
      next_cycle();
      m0_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_ack_at_expiry();
      int bad = 0;
      m0_req(1'b1);
      next_cycle();
      for (int i = 1; i < 16; i++) begin
         sample();
         if (timeout_o || m0_err_o) bad++;
         next_cycle();
      end
      slave_ack(1'b0, 64'h9abc_def0_1234_5678);
      sample();
      checks++;
      if (bad != 0 || m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_at_expiry got early=%0d ack=%b err=%b to=%b required 0 1 0 0", bad,
                  m0_ack_o, m0_err_o, timeout_o);
      end
      next_cycle();
      m0_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset_mid_burst();
      m1_req(1'b1);
      m1_cti_i = 3'b010;
      m1_adr_i = 32'h0000_c000;
      m1_dat_i = 64'hface_face_face_face;
      next_cycle();
      slave_ack(1'b1, 64'ha1);
      sample();
      checks++;
      if (grant_o !== 2'b10) begin
         errors++;
         $display("FAIL rst_mid_owner got grant=%b required 10", grant_o);
      end
      next_cycle();
      slave_ack(1'b1, 64'ha2);
      wb_rst = 1'b1;
      next_cycle();
      wb_rst = 1'b0;
      m1_req(1'b0);
      s_dat_i = 64'hbad0_bad0_bad0_bad0;
      sample();
      checks++;
      if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_adr_o !== 32'h0 || s_dat_o !== 64'h0 ||
          s_cti_o !== 3'b0 || m1_ack_o !== 1'b0 || m1_dat_o !== 64'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs got grant=%b cyc=%b adr=%h dat=%h ack=%b rdat=%h required 0",
                  grant_o, s_cyc_o, s_adr_o, s_dat_o, m1_ack_o, m1_dat_o);
      end
      next_cycle();
      s_ack_i = 1'b0;
      m0_req(1'b1);
      next_cycle();
      slave_ack(1'b0, 64'hb1);
      sample();
      checks++;
      if (grant_o !== 2'b01 || s_cyc_o !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_regrant got grant=%b cyc=%b required 01 1", grant_o, s_cyc_o);
      end
      next_cycle();
      m0_req(1'b0);
      s_ack_i = 1'b0;
      next_cycle();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_m0_burst();
      test_simultaneous();
      test_consec();
      test_timeout();
      test_ack_at_expiry();
      test_reset_mid_burst();
      sample();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending responses required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
